// File: rtl/hh_membrane_update.sv
// hh_membrane_update: forward-Euler membrane integrator for a Hodgkin-Huxley
// neuron. It publishes V, collects n/m/h over a req/ack handshake and sums
// I_K + I_Na + I_L on one shared multiplier, one product per cycle.
// Ports: clk, reset (async, active-high), en, i_ext (Q8.8),
//   gate_n/m/h (Q0.16) + gate_ack in; v_req, v_out (Q8.8), v_valid out.
module hh_membrane_update #(
  parameter logic signed [15:0] V_REST   = -16'sd16640,
  parameter logic [15:0]        G_K      = 16'd9216,
  parameter logic [15:0]        G_NA     = 16'd30720,
  parameter logic [15:0]        G_L      = 16'd77,
  parameter logic signed [15:0] E_K      = -16'sd19712,
  parameter logic signed [15:0] E_NA     = 16'sd12800,
  parameter logic signed [15:0] E_L      = -16'sd13926,
  parameter int                 DT_SHIFT = 6
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               en,
  input  logic signed [15:0] i_ext,
  input  logic [15:0]        gate_n,
  input  logic [15:0]        gate_m,
  input  logic [15:0]        gate_h,
  input  logic               gate_ack,
  output logic               v_req,
  output logic signed [15:0] v_out,
  output logic               v_valid
);

  typedef enum logic [1:0] {IDLE, REQ, MUL, UPDATE} state_t;

  state_t             state, state_nx;
  logic [3:0]         step;
  logic [15:0]        n_q, m_q, h_q, tmp;
  logic signed [39:0] acc;
  logic signed [17:0] op_a, op_b;
  logic signed [35:0] prod;
  logic               is_cur;
  logic               take;
  logic signed [16:0] d_k, d_na, d_l;
  logic signed [40:0] net, dv;
  logic signed [41:0] vsum;
  logic signed [15:0] v_sat;

  function automatic logic signed [17:0] u18(input logic [15:0] x);
    return $signed({2'b00, x});
  endfunction

  function automatic logic signed [17:0] s18(input logic signed [16:0] x);
    return $signed({x[16], x});
  endfunction

  assign d_k  = 17'(v_out) - 17'(E_K);
  assign d_na = 17'(v_out) - 17'(E_NA);
  assign d_l  = 17'(v_out) - 17'(E_L);

  // Gate-fraction products keep [31:16]; current products are Q8.8 * Q8.8
  // and drop 8 fraction bits before accumulating.
  always_comb begin
    op_a   = '0;
    op_b   = '0;
    is_cur = 1'b0;
    unique case (step)
      4'd0: begin op_a = u18(n_q);  op_b = u18(n_q); end
      4'd1: begin op_a = u18(tmp);  op_b = u18(tmp); end
      4'd2: begin op_a = u18(G_K);  op_b = u18(tmp); end
      4'd3: begin
        op_a = u18(tmp); op_b = s18(d_k); is_cur = 1'b1;
      end
      4'd4: begin op_a = u18(m_q);  op_b = u18(m_q); end
      4'd5: begin op_a = u18(tmp);  op_b = u18(m_q); end
      4'd6: begin op_a = u18(tmp);  op_b = u18(h_q); end
      4'd7: begin op_a = u18(G_NA); op_b = u18(tmp); end
      4'd8: begin
        op_a = u18(tmp); op_b = s18(d_na); is_cur = 1'b1;
      end
      4'd9: begin
        op_a = u18(G_L); op_b = s18(d_l); is_cur = 1'b1;
      end
      default: ;
    endcase
  end

  assign prod = op_a * op_b;

  assign net  = 41'(i_ext) - 41'(acc);
  assign dv   = net >>> DT_SHIFT;
  assign vsum = 42'(v_out) + 42'(dv);

  always_comb begin
    v_sat = vsum[15:0];
    if (vsum > 42'sd32767)
      v_sat = 16'sh7fff;
    else if (vsum < -42'sd32768)
      v_sat = 16'sh8000;
  end

  // Ack only counts once v_req is visibly high.
  assign take = en && v_req && gate_ack;

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:   if (en) state_nx = REQ;
      REQ: begin
        if (!en)       state_nx = IDLE;
        else if (take) state_nx = MUL;
      end
      MUL:    if (step == 4'd9) state_nx = UPDATE;
      UPDATE: state_nx = en ? REQ : IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      v_out   <= V_REST;
      v_req   <= 1'b0;
      v_valid <= 1'b0;
      acc     <= '0;
      step    <= '0;
      tmp     <= '0;
      n_q     <= '0;
      m_q     <= '0;
      h_q     <= '0;
    end else begin
      state   <= state_nx;
      v_req   <= (state == REQ) && (state_nx == REQ);
      v_valid <= (state == UPDATE);
      unique case (state)
        REQ: begin
          if (take) begin
            n_q  <= gate_n;
            m_q  <= gate_m;
            h_q  <= gate_h;
            acc  <= '0;
            step <= '0;
          end
        end
        MUL: begin
          step <= step + 4'd1;
          if (is_cur)
            acc <= acc + 40'(prod >>> 8);
          else
            tmp <= prod[31:16];
        end
        UPDATE: v_out <= v_sat;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_hh_membrane_update.sv
// tb_hh_membrane_update: directed vectors for the HH membrane integrator.
// Expected potentials are hand-computed from the fixed-point update rules.
module tb_hh_membrane_update;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic               en = 1'b1;
  logic signed [15:0] i_ext = '0;
  logic [15:0]        gate_n = '0, gate_m = '0, gate_h = '0;
  logic               gate_ack = 1'b0;
  logic               v_req, v_valid;
  logic signed [15:0] v_out;

  int n_chk = 0;
  int n_fail = 0;

  hh_membrane_update dut (
    .clk(clk), .reset(reset), .en(en), .i_ext(i_ext),
    .gate_n(gate_n), .gate_m(gate_m), .gate_h(gate_h),
    .gate_ack(gate_ack), .v_req(v_req), .v_out(v_out),
    .v_valid(v_valid)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached, summary not yet printed");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Wait for v_req, optionally stall, ack with the given gates, then wait
  // for v_valid. lat counts negedges after the ack edge.
  task automatic do_step(input logic [15:0] n, input logic [15:0] m,
                         input logic [15:0] h, input int ie,
                         input int stall, input string tag,
                         output int vnew, output int lat);
    int t;
    int v0;
    bit ok;
    t = 0;
    while (v_req !== 1'b1 && t < 50) begin
      @(negedge clk);
      t++;
    end
    chk({tag, " v_req"}, int'(v_req), 1);
    v0 = v_out;
    ok = 1'b1;
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      if (v_req !== 1'b1 || v_valid !== 1'b0 || v_out != v0) ok = 1'b0;
    end
    if (stall > 0) chk({tag, " stall"}, int'(ok), 1);
    i_ext = 16'(ie);
    gate_n = n;
    gate_m = m;
    gate_h = h;
    gate_ack = 1'b1;
    @(negedge clk);
    gate_ack = 1'b0;
    gate_n = 16'hffff;
    gate_m = 16'hffff;
    gate_h = 16'hffff;
    lat = 0;
    while (v_valid !== 1'b1 && lat < 30) begin
      @(negedge clk);
      lat++;
    end
    vnew = v_out;
  endtask

  typedef struct {
    logic [15:0] n, m, h;
    int          ie;
    int          stall;
    int          exp_v;
  } vec_t;

  vec_t tbl[6];

  initial begin
    int v, lat, cnt, vsave, prev;
    bit mono, lat_ok;

    tbl[0] = '{16'h0000, 16'h0000, 16'h0000, 0,     0,  -16628};
    tbl[1] = '{16'h0000, 16'h0000, 16'h0000, 0,     50, -16616};
    tbl[2] = '{16'h0000, 16'h0000, 16'h0000, 256,   0,  -16600};
    tbl[3] = '{16'h0000, 16'h0000, 16'h0000, -1280, 3,  -16608};
    tbl[4] = '{16'h0000, 16'h8000, 16'hffff, 0,     0,  -9705};
    tbl[5] = '{16'h8000, 16'h0000, 16'h0000, 0,     0,  -10077};

    // Reset values and release timing
    repeat (3) @(negedge clk);
    chk("rst v_out", v_out, -16640);
    chk("rst v_req", int'(v_req), 0);
    chk("rst v_valid", int'(v_valid), 0);
    reset = 1'b0;
    @(negedge clk);
    chk("rel edge1 v_req", int'(v_req), 0);
    @(negedge clk);
    chk("rel edge2 v_req", int'(v_req), 1);

    // Table-driven update chain
    foreach (tbl[i]) begin
      do_step(tbl[i].n, tbl[i].m, tbl[i].h, tbl[i].ie, tbl[i].stall,
              $sformatf("vec%0d", i), v, lat);
      chk($sformatf("vec%0d v_out", i), v, tbl[i].exp_v);
      chk($sformatf("vec%0d latency", i), lat, 11);
      chk($sformatf("vec%0d v_req low", i), int'(v_req), 0);
      @(negedge clk);
      chk($sformatf("vec%0d pulse", i), int'(v_valid), 0);
      chk($sformatf("vec%0d v_req back", i), int'(v_req), 1);
    end

    // Reset mid-MUL discards the update
    gate_ack = 1'b1;
    @(negedge clk);
    gate_ack = 1'b0;
    repeat (4) @(negedge clk);
    reset = 1'b1;
    #1;
    chk("midrst v_out", v_out, -16640);
    chk("midrst v_req", int'(v_req), 0);
    chk("midrst v_valid", int'(v_valid), 0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("midrst edge1 v_req", int'(v_req), 0);
    @(negedge clk);
    chk("midrst edge2 v_req", int'(v_req), 1);

    // K path from rest: I_K = 6912, I_L = -817 -> dV = -96
    do_step(16'h8000, 16'h0000, 16'h0000, 0, 0, "kpath", v, lat);
    chk("kpath v_out", v, -16736);
    chk("kpath latency", lat, 11);
    @(negedge clk);

    // en dropped mid-MUL: the update still completes, then IDLE
    i_ext = '0;
    gate_n = '0;
    gate_m = '0;
    gate_h = '0;
    gate_ack = 1'b1;
    @(negedge clk);
    gate_ack = 1'b0;
    repeat (3) @(negedge clk);
    en = 1'b0;
    cnt = 0;
    vsave = 0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      if (v_valid === 1'b1) begin
        cnt++;
        vsave = v_out;
      end
    end
    chk("endrop pulses", cnt, 1);
    chk("endrop v_out", vsave, -16723);
    chk("endrop idle v_req", int'(v_req), 0);
    en = 1'b1;
    @(negedge clk);
    chk("reen edge1 v_req", int'(v_req), 0);
    @(negedge clk);
    chk("reen edge2 v_req", int'(v_req), 1);

    // en dropped in REQ with a same-cycle ack: ack ignored
    en = 1'b0;
    gate_n = 16'hffff;
    gate_m = 16'hffff;
    gate_h = 16'hffff;
    gate_ack = 1'b1;
    @(negedge clk);
    gate_ack = 1'b0;
    chk("reqdrop v_req", int'(v_req), 0);
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (v_valid === 1'b1) cnt++;
    end
    chk("reqdrop pulses", cnt, 0);
    chk("reqdrop v_out", v_out, -16723);
    en = 1'b1;

    // Saturation at +32767 without wrap
    prev = v_out;
    mono = 1'b1;
    lat_ok = 1'b1;
    cnt = 0;
    for (int i = 0; i < 400; i++) begin
      do_step(16'h0, 16'h0, 16'h0, 32767, 0, "sat", v, lat);
      if (v < prev) mono = 1'b0;
      if (lat != 11) lat_ok = 1'b0;
      if (v == 32767) cnt++;
      prev = v;
    end
    chk("sat monotonic", int'(mono), 1);
    chk("sat latency", int'(lat_ok), 1);
    chk("sat final", prev, 32767);
    chk("sat held", int'(cnt > 200), 1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
